// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: E-stage forwarding, D-stage read bypass, load-use stall,
// branch flush, and a small FSM that holds E for the duration of a MUL/DIV.
module hazard_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       loadE,
  input  logic       PCSrcE,
  input  logic       mdu_startE,
  input  logic       mdu_divE,
  output logic       stallF,
  output logic       stallD,
  output logic       mdu_hold,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       n_for1_4A,
  output logic       n_for1_4B,
  output logic       mdu_busy,
  output logic       mdu_valid,
  output logic [4:0] mdu_rd
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // The start cycle and the DONE cycle are not counted, hence the -2 preload.
  localparam logic [7:0] MUL_LOAD = 8'(MUL_LAT - 2);
  localparam logic [7:0] DIV_LOAD = 8'(DIV_LAT - 2);

  logic [1:0] state;
  logic [7:0] cnt;
  logic [4:0] rd_q;
  logic       lw_stall;
  logic       hold_int;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
      rd_q  <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mdu_startE) begin
            cnt   <= mdu_divE ? DIV_LOAD : MUL_LOAD;
            rd_q  <= RdE;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 8'd0) state <= DONE;
          else             cnt   <= cnt - 8'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    forwardAE = 2'b00;
    if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)      forwardAE = 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E) forwardAE = 2'b01;
  end

  always_comb begin
    forwardBE = 2'b00;
    if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)      forwardBE = 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E) forwardBE = 2'b01;
  end

  assign n_for1_4A = RegWriteW && RdW != 5'd0 && RdW == Rs1D;
  assign n_for1_4B = RegWriteW && RdW != 5'd0 && RdW == Rs2D;

  assign lw_stall = loadE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);

  // Everything below is gated by rst_n so outputs are quiet before the first reset edge.
  assign hold_int = rst_n && ((state == IDLE && mdu_startE) || state == BUSY);

  assign mdu_hold  = hold_int;
  assign flushM    = hold_int;
  assign stallF    = rst_n && (lw_stall || hold_int) && !PCSrcE;
  assign stallD    = stallF;
  assign flushD    = rst_n && PCSrcE && !hold_int;
  assign flushE    = rst_n && (lw_stall || PCSrcE) && !hold_int;

  assign mdu_busy  = rst_n && (state == BUSY || state == DONE);
  assign mdu_valid = rst_n && state == DONE;
  assign mdu_rd    = rd_q & {5{rst_n}};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// checked against an elapsed-cycle reference model of the hazard rules.
module tb_hazard_ctrl;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 33;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, loadE, PCSrcE, mdu_startE, mdu_divE;
  logic       stallF, stallD, mdu_hold, flushD, flushE, flushM;
  logic [1:0] forwardAE, forwardBE;
  logic       n_for1_4A, n_for1_4B, mdu_busy, mdu_valid;
  logic [4:0] mdu_rd;

  int checks = 0;
  int errors = 0;

  // Reference model: age = cycles elapsed since the MDU op was accepted (-1 = idle)
  int         m_age = -1;
  int         m_lat = 0;
  logic [4:0] m_rd  = 5'd0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .loadE(loadE), .PCSrcE(PCSrcE),
    .mdu_startE(mdu_startE), .mdu_divE(mdu_divE),
    .stallF(stallF), .stallD(stallD), .mdu_hold(mdu_hold),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .n_for1_4A(n_for1_4A), .n_for1_4B(n_for1_4B),
    .mdu_busy(mdu_busy), .mdu_valid(mdu_valid), .mdu_rd(mdu_rd)
  );

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwdSel(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic checkModel();
    bit hold, lw, stall;
    hold  = rst_n && ((m_age < 0 && mdu_startE) || (m_age >= 1 && m_age < m_lat));
    lw    = loadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    stall = rst_n && (lw || hold) && !PCSrcE;
    checkOutput("mdu_hold",  {7'd0, mdu_hold},  {7'd0, hold});
    checkOutput("flushM",    {7'd0, flushM},    {7'd0, hold});
    checkOutput("stallF",    {7'd0, stallF},    {7'd0, stall});
    checkOutput("stallD",    {7'd0, stallD},    {7'd0, stall});
    checkOutput("flushD",    {7'd0, flushD},    {7'd0, rst_n && PCSrcE && !hold});
    checkOutput("flushE",    {7'd0, flushE},    {7'd0, rst_n && (lw || PCSrcE) && !hold});
    checkOutput("forwardAE", {6'd0, forwardAE}, {6'd0, fwdSel(Rs1E)});
    checkOutput("forwardBE", {6'd0, forwardBE}, {6'd0, fwdSel(Rs2E)});
    checkOutput("n_for1_4A", {7'd0, n_for1_4A}, {7'd0, RegWriteW && RdW != 0 && RdW == Rs1D});
    checkOutput("n_for1_4B", {7'd0, n_for1_4B}, {7'd0, RegWriteW && RdW != 0 && RdW == Rs2D});
    checkOutput("mdu_busy",  {7'd0, mdu_busy},  {7'd0, rst_n && m_age >= 1});
    checkOutput("mdu_valid", {7'd0, mdu_valid}, {7'd0, rst_n && m_age == m_lat});
    checkOutput("mdu_rd",    {3'd0, mdu_rd},    {3'd0, (rst_n ? m_rd : 5'd0)});
  endtask

  task automatic stepModel();
    if (!rst_n) begin
      m_age = -1;
      m_rd  = 5'd0;
    end else if (m_age < 0) begin
      if (mdu_startE) begin
        m_age = 1;
        m_lat = mdu_divE ? DIV_LAT : MUL_LAT;
        m_rd  = RdE;
      end
    end else if (m_age == m_lat) begin
      m_age = -1;
    end else begin
      m_age++;
    end
  endtask

  task automatic sampleCycle();
    @(negedge clk);
    checkModel();
  endtask

  task automatic advanceCycle();
    @(posedge clk);
    stepModel();
    #1;
  endtask

  task automatic clearInputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; loadE = 0; PCSrcE = 0; mdu_startE = 0; mdu_divE = 0;
  endtask

  task automatic applyStimulus();
    int r;
    Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
    Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
    RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
    RdW  = 5'($urandom_range(0, 3));
    RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
    r = $urandom_range(0, 9);
    loadE      = (r <= 1);
    PCSrcE     = (r == 2);
    mdu_startE = (r == 3);
    mdu_divE   = ($urandom_range(0, 3) == 0);
    rst_n      = ($urandom_range(0, 39) != 0);
  endtask

  initial begin
    clearInputs();
    rst_n = 1'b0;
    mdu_startE = 1'b1;
    sampleCycle(); advanceCycle();
    clearInputs();
    sampleCycle(); advanceCycle();
    rst_n = 1'b1;
    sampleCycle(); advanceCycle();

    // Forwarding priority: M over W, zero register never forwards
    RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5;
    sampleCycle(); checkOutput("fwdA_M", {6'd0, forwardAE}, 8'h02);
    RdM = 0;
    sampleCycle(); checkOutput("fwdA_W", {6'd0, forwardAE}, 8'h01);
    RdW = 0;
    sampleCycle(); checkOutput("fwdA_reg", {6'd0, forwardAE}, 8'h00);
    advanceCycle(); clearInputs();

    // Load-use hazard, then the same with a zero destination
    loadE = 1; RdE = 7; Rs2D = 7;
    sampleCycle();
    checkOutput("lw_stallF", {7'd0, stallF}, 8'h01);
    checkOutput("lw_flushE", {7'd0, flushE}, 8'h01);
    checkOutput("lw_flushD", {7'd0, flushD}, 8'h00);
    RdE = 0;
    sampleCycle();
    checkOutput("lw0_stallF", {7'd0, stallF}, 8'h00);
    checkOutput("lw0_flushE", {7'd0, flushE}, 8'h00);
    advanceCycle(); clearInputs();

    // D-stage write-through bypass
    RegWriteW = 1; RdW = 3; Rs1D = 3; Rs2D = 4;
    sampleCycle();
    checkOutput("bypA", {7'd0, n_for1_4A}, 8'h01);
    checkOutput("bypB", {7'd0, n_for1_4B}, 8'h00);
    RdW = 0;
    sampleCycle();
    checkOutput("bypA0", {7'd0, n_for1_4A}, 8'h00);
    advanceCycle(); clearInputs();

    // Multiply: E held for cycles 0..2, result valid in cycle 3, idle in cycle 4
    for (int c = 0; c <= 4; c++) begin
      mdu_startE = (c <= 3); mdu_divE = 0; RdE = 9;
      sampleCycle();
      checkOutput("mul_hold",  {7'd0, mdu_hold},  {7'd0, c <= 2});
      checkOutput("mul_stall", {7'd0, stallF},    {7'd0, c <= 2});
      checkOutput("mul_valid", {7'd0, mdu_valid}, {7'd0, c == 3});
      checkOutput("mul_busy",  {7'd0, mdu_busy},  {7'd0, c >= 1 && c <= 3});
      advanceCycle();
    end
    clearInputs();

    // Divide with a taken branch mid-operation: the held instruction is never flushed
    for (int c = 0; c <= 34; c++) begin
      mdu_startE = (c <= 33); mdu_divE = 1; RdE = 12; PCSrcE = (c == 10);
      sampleCycle();
      checkOutput("div_hold",  {7'd0, mdu_hold},  {7'd0, c <= 32});
      checkOutput("div_valid", {7'd0, mdu_valid}, {7'd0, c == 33});
      if (c <= 32) begin
        checkOutput("div_flushD", {7'd0, flushD}, 8'h00);
        checkOutput("div_flushE", {7'd0, flushE}, 8'h00);
      end
      advanceCycle();
    end
    clearInputs();

    // Reset in the middle of a divide
    for (int c = 0; c <= 6; c++) begin
      mdu_startE = (c <= 5); mdu_divE = 1; RdE = 17; rst_n = (c != 5);
      sampleCycle();
      if (c == 5) checkOutput("rst_hold", {7'd0, mdu_hold}, 8'h00);
      if (c == 6) begin
        checkOutput("rst_busy", {7'd0, mdu_busy}, 8'h00);
        checkOutput("rst_hold_after", {7'd0, mdu_hold}, 8'h00);
        checkOutput("rst_rd", {3'd0, mdu_rd}, 8'h00);
      end
      advanceCycle();
    end
    clearInputs();
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      sampleCycle();
      advanceCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 3, SHALL set the E-stage hold cycles for multiply (legal range 2..255).
REQ-002 Parameter DIV_LAT, default 33, SHALL set the E-stage hold cycles for divide (legal range 2..255).
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 Rs1D, Rs2D  in  5 each  D-stage source register indices.
REQ-006 Rs1E, Rs2E, RdE  in  5 each  E-stage source and destination indices.
REQ-007 RdM, RdW  in  5 each  M- and W-stage destination indices.
REQ-008 RegWriteM, RegWriteW  in  1 each  M/W instructions write the register file.
REQ-009 loadE  in  1  E-stage instruction is a load.
REQ-010 PCSrcE  in  1  taken branch/jump resolved in E.
REQ-011 mdu_startE  in  1  E-stage instruction is MUL/DIV; mdu_divE  in  1  1 = divide, 0 = multiply.
REQ-012 stallF, stallD  out  1 each  hold the F and D pipeline registers.
REQ-013 mdu_hold  out  1  hold the E-stage register and MDU operands.
REQ-014 flushD, flushE, flushM  out  1 each  zero the D, E, M pipeline registers at the next edge.
REQ-015 forwardAE, forwardBE  out  2 each  E operand select: 00 register, 10 from M, 01 from W.
REQ-016 n_for1_4A, n_for1_4B  out  1 each  D-stage read bypass of WD3 for Rs1D/Rs2D.
REQ-017 mdu_busy  out  1  MDU FSM not IDLE; mdu_valid  out  1  MDU result enters M this cycle; mdu_rd  out  5  latched MDU destination.

Function
REQ-018 Forwarding SHALL be combinational: forwardAE = 10 if RegWriteM & RdM != 0 & RdM == Rs1E; else 01 if RegWriteW & RdW != 0 & RdW == Rs1E; else 00; forwardBE identical using Rs2E. M wins over W.
REQ-019 n_for1_4A SHALL equal RegWriteW & RdW != 0 & RdW == Rs1D; n_for1_4B likewise with Rs2D.
REQ-020 lwStall SHALL equal loadE & RdE != 0 & (RdE == Rs1D | RdE == Rs2D).
REQ-021 MDU FSM states SHALL be IDLE, BUSY, DONE with an 8-bit down-counter cnt.
REQ-022 IDLE: if mdu_startE, cnt <= (mdu_divE ? DIV_LAT : MUL_LAT) - 2, mdu_rd <= RdE, next BUSY; else stay IDLE.
REQ-023 BUSY: if cnt == 0 next DONE, else cnt <= cnt - 1.
REQ-024 DONE: next IDLE unconditionally; mdu_valid = 1 only in DONE.
REQ-025 mdu_hold SHALL be 1 when (IDLE & mdu_startE) or BUSY; E is therefore held exactly MUL_LAT/DIV_LAT cycles, and the result enters M at the end of the DONE cycle.
REQ-026 flushM SHALL equal mdu_hold, inserting a bubble into M each hold cycle.
REQ-027 stallF = stallD = (lwStall | mdu_hold) & ~PCSrcE.
REQ-028 flushD SHALL equal PCSrcE & ~mdu_hold.
REQ-029 flushE SHALL equal (lwStall | PCSrcE) & ~mdu_hold; the held MDU instruction SHALL never be flushed.
REQ-030 loadE, PCSrcE and mdu_startE are mutually exclusive by decode; if PCSrcE and lwStall coincide, PCSrcE wins per REQ-027..029.
REQ-031 mdu_startE while BUSY or DONE SHALL NOT restart the FSM or reload cnt/mdu_rd.
REQ-032 mdu_busy SHALL be 1 in BUSY and DONE.

Reset
REQ-033 rst_n low at a rising edge SHALL force IDLE, cnt = 0, mdu_rd = 0, regardless of state, including mid-BUSY.
REQ-034 While rst_n is low, all registered outputs SHALL read 0 and mdu_hold, stalls and flushes SHALL be 0 irrespective of other inputs.
REQ-035 The first edge with rst_n high SHALL evaluate normally from IDLE.

Verification
REQ-036 RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5 -> forwardAE=10; RdM=0 instead -> forwardAE=01; RdW=0 too -> 00.
REQ-037 loadE=1, RdE=7, Rs2D=7 -> stallF=stallD=flushE=1, flushD=0; RdE=0 -> all 0.
REQ-038 mdu_startE=1, mdu_divE=0 at cycle 0 -> mdu_hold=flushM=stallF=1 cycles 0-2, mdu_valid=1 cycle 3, IDLE cycle 4.
REQ-039 Divide start at cycle 0 with PCSrcE=1 pulsed at cycle 10 -> mdu_hold 1 cycles 0-32, flushD=flushE=0 throughout hold, mdu_valid=1 cycle 33.
REQ-040 Divide start, rst_n low at cycle 5 -> cycle 6 IDLE, mdu_busy=0, mdu_hold=0, mdu_rd=0.
REQ-041 RegWriteW=1, RdW=3, Rs1D=3, Rs2D=4 -> n_for1_4A=1, n_for1_4B=0; RdW=0 -> both 0.
